// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding, instruction size
// and the default boot address.
package fetch_pkg;

   typedef enum logic [1:0] {StIdle, StFetch, StHold, StFlush} fetch_state_e;

   localparam int unsigned INSN_BYTES = 4;
   localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'hFFFF_FFFF_FFFF_FF00;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction-fetch sequencer: one bus cycle at a time, single-entry instruction buffer
// toward decode, redirects at any time with stale bus data discarded.
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter int unsigned   AW           = 64,
   parameter logic [AW-1:0] RESET_VECTOR = AW'(DEFAULT_RESET_VECTOR)
) (
   input  logic          clk_i,
   input  logic          reset_i,
   output logic [AW-1:0] iadr_o,
   output logic          istb_o,
   input  logic          iack_i,
   input  logic [31:0]   idat_i,
   input  logic          jump_i,
   input  logic [AW-1:0] jump_target_i,
   output logic [31:0]   ir_o,
   output logic [AW-1:0] pc_o,
   output logic          ir_valid_o,
   input  logic          ir_ready_i
);

   fetch_state_e  state_q, state_d;
   logic [AW-1:0] fpc_q, fpc_d;
   logic [AW-1:0] redirect_q, redirect_d;
   logic [31:0]   ir_q, ir_d;
   logic [AW-1:0] pc_q, pc_d;
   logic          valid_q, valid_d;
   logic [AW-1:0] target;

   assign target = {jump_target_i[AW-1:2], 2'b00};

   // Low target bits are architecturally ignored.
   logic unused_target_lsbs;
   assign unused_target_lsbs = ^jump_target_i[1:0];

   always_comb begin
      state_d    = state_q;
      fpc_d      = fpc_q;
      redirect_d = redirect_q;
      ir_d       = ir_q;
      pc_d       = pc_q;
      valid_d    = valid_q;
      unique case (state_q)
         StIdle: begin
            state_d = StFetch;
         end
         StFetch: begin
            if (jump_i) begin
               if (iack_i) begin
                  fpc_d = target;
               end else begin
                  // The open bus cycle keeps its address; the target waits in redirect_q.
                  redirect_d = target;
                  state_d    = StFlush;
               end
            end else if (iack_i) begin
               ir_d    = idat_i;
               pc_d    = fpc_q;
               valid_d = 1'b1;
               fpc_d   = fpc_q + AW'(INSN_BYTES);
               state_d = StHold;
            end
         end
         StHold: begin
            if (jump_i) begin
               fpc_d   = target;
               valid_d = 1'b0;
               state_d = StFetch;
            end else if (ir_ready_i) begin
               valid_d = 1'b0;
               state_d = StFetch;
            end
         end
         StFlush: begin
            if (jump_i) begin
               redirect_d = target;
            end
            if (iack_i) begin
               fpc_d   = jump_i ? target : redirect_q;
               state_d = StFetch;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= StIdle;
         fpc_q      <= RESET_VECTOR;
         redirect_q <= '0;
         ir_q       <= '0;
         pc_q       <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         fpc_q      <= fpc_d;
         redirect_q <= redirect_d;
         ir_q       <= ir_d;
         pc_q       <= pc_d;
         valid_q    <= valid_d;
      end
   end

   assign iadr_o     = fpc_q;
   assign istb_o     = (state_q == StFetch) || (state_q == StFlush);
   assign ir_o       = ir_q;
   assign pc_o       = pc_q;
   assign ir_valid_o = valid_q;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch sequencer feeding the processor's instruction bus. Holds the fetch PC, issues one bus cycle at a time (address plus strobe, wait for acknowledge) toward the address decoder and ROM, and buffers one fetched instruction for the decode stage behind a valid/ready handshake. Accepts branch/jump redirects at any time and discards stale fetches.

## Interface
- `AW`, 64: instruction-address width.
- `RESET_VECTOR`, 64'hFFFF_FFFF_FFFF_FF00: first fetch address after reset; bits [1:0] must be 0.
- `clk_i` in 1: clock.
- `reset_i` in 1: reset, synchronous, active-high.
- `iadr_o` out AW: bus address; bits [1:0] always 0.
- `istb_o` out 1: bus strobe.
- `iack_i` in 1: bus acknowledge; may be asserted in the same cycle as `istb_o`.
- `idat_i` in 32: instruction word; valid when `iack_i` is high.
- `jump_i` in 1: redirect request.
- `jump_target_i` in AW: redirect address; bits [1:0] ignored and forced to 0.
- `ir_o` out 32: buffered instruction.
- `pc_o` out AW: address of `ir_o`.
- `ir_valid_o` out 1: `ir_o` and `pc_o` hold an unconsumed instruction.
- `ir_ready_i` in 1: decode accepts `ir_o` this cycle.

## Operation
- States: `IDLE` (reset only), `FETCH`, `HOLD`, `FLUSH`. `istb_o` = (state is `FETCH` or `FLUSH`). `iadr_o` = fetch PC register.
- Reset (edge with `reset_i` high): state `IDLE`. Fetch PC = `RESET_VECTOR`. `ir_valid_o` = 0, `ir_o` = 0, `pc_o` = 0, so `istb_o` = 0.
- `IDLE`: next edge with `reset_i` low goes to `FETCH`.
- `FETCH`, `iack_i` high, no jump: latch `idat_i` into `ir_o` and fetch PC into `pc_o`. Set `ir_valid_o`. Fetch PC += 4 modulo 2^AW. Go to `HOLD`.
- `FETCH`, no `iack_i`: hold; `iadr_o`/`istb_o` stay stable until acknowledged.
- `HOLD`: `istb_o` = 0. When `ir_ready_i` is high, clear `ir_valid_o` and go to `FETCH`.
- Redirects (`jump_i` high; the jump target is always loaded into the fetch PC):
  - `FETCH` with `iack_i` in the same cycle: discard `idat_i`; stay `FETCH` (new address next cycle).
  - `FETCH` without `iack_i`: go to `FLUSH`; the bus cycle in flight keeps its old address until acknowledged.
  - `FLUSH`: wait for `iack_i`, discard the data, then go to `FETCH`. A further jump in `FLUSH` overwrites the target and stays in `FLUSH`.
  - `HOLD`: clear `ir_valid_o` and go to `FETCH`. A jump together with `ir_ready_i` counts as the handshake completing; the jump still takes effect.
  - `IDLE`: ignored.
- Discarded data never reaches `ir_o`, and `ir_valid_o` never rises for it.
- Reset mid-cycle (any state, including `FLUSH`): abandon the cycle and return to `IDLE` with the reset values. The bus slave must tolerate a strobe dropping without an acknowledge.

## Timing
- Cycle 0 = first cycle with `reset_i` low: `istb_o` = 0. Cycle 1: `istb_o` = 1, `iadr_o` = `RESET_VECTOR`.
- Zero-wait ROM (`iack_i` = `istb_o`): `ir_valid_o` is high the cycle after the acknowledge.
- Peak throughput: one instruction per 2 cycles (fetch, hold).
- Wait states: each cycle of `iack_i` delay adds one cycle to fetch latency.
- Redirect latency:
  - From `HOLD`, or from `FETCH` with a same-cycle acknowledge: the new address appears on `iadr_o` the cycle after `jump_i`.
  - From `FLUSH`: the new address appears the cycle after the pending acknowledge.
- `ir_o`/`pc_o` stay constant while `ir_valid_o` is high and `ir_ready_i` is low.
- All outputs are driven from registers only. No combinational path from any input to any output.

## Structure
- Shared package `fetch_pkg`:
  - state enum
  - `INSN_BYTES` = 4
  - default `RESET_VECTOR`
- No sub-module is natural; single module.

## Test plan
- Reset release, zero-wait ROM returning 32'h0000_0013, `ir_ready_i` = 1:
  - cycle 1: `iadr_o` = FFFF_FFFF_FFFF_FF00
  - cycle 2: `ir_valid_o` = 1, `pc_o` = FF00-vector
  - next fetch at …FF04.
- Backpressure: `ir_ready_i` low for 5 cycles -> `istb_o` stays 0, `ir_o`/`pc_o` stable; `ir_ready_i` high -> fetch at PC+4 next cycle.
- Wait states: acknowledge delayed 3 cycles -> `iadr_o` stable with `istb_o` high for 4 cycles; `ir_valid_o` rises the cycle after the acknowledge.
- Jump in `FETCH` with acknowledge delayed 2 cycles, target 64'h1000:
  - old cycle completes and its data is discarded (`ir_valid_o` stays 0)
  - then `iadr_o` = 64'h1000.
- Jump in `HOLD` to 64'h2002: `ir_valid_o` drops; next `iadr_o` = 64'h2000.
- Wrap-around: `RESET_VECTOR` = 64'hFFFF_FFFF_FFFF_FFFC -> second fetch address 0. Reset asserted during `FLUSH` -> `istb_o` = 0, `ir_valid_o` = 0 next cycle; fetch restarts at `RESET_VECTOR`.
